// File: rtl/lfsr_gen_if.sv
// rtl/lfsr_gen_if.sv - control and status bundle for the LFSR pattern generator
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       mode;
    logic             step;
    logic             start;
    logic [15:0]      burst_len;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] state_o;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [WIDTH-1:0] period;

    modport master (
        output mode, step, start, burst_len, load, load_val,
        input  state_o, busy, done, wrap, period
    );

    modport slave (
        input  mode, step, start, burst_len, load, load_val,
        output state_o, busy, done, wrap, period
    );
endinterface

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci LFSR with run/step/burst modes and period measurement
module lfsr_gen #(
    parameter int          WIDTH    = 8,
    parameter logic [31:0] TAP_MASK = 32'h1D,
    parameter logic [31:0] SEED     = 32'h1
) (
    input  logic       clk,
    input  logic       rst,
    lfsr_gen_if.slave  bus
);
    localparam logic [WIDTH-1:0] L_TAPS = TAP_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_SEED = SEED[WIDTH-1:0];

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_origin;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [15:0]      r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_adv;
    logic             w_burst_req;

    always_comb begin
        w_fb        = ^(r_state & L_TAPS);
        // The all-zero state is a lock-up point; escape to the seed instead.
        w_next      = (r_state == '0) ? L_SEED : {w_fb, r_state[WIDTH-1:1]};
        w_load_val  = (bus.load_val == '0) ? L_SEED : bus.load_val;
        w_adv       = !bus.load &&
                      (r_busy || (bus.mode == 2'b01) || ((bus.mode == 2'b10) && bus.step));
        w_burst_req = !r_busy && bus.start && (bus.mode == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= L_SEED;
            r_origin <= L_SEED;
            r_cnt    <= '0;
            r_period <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;

            if (bus.load) begin
                r_state  <= w_load_val;
                r_origin <= w_load_val;
                r_cnt    <= '0;
            end else if (w_adv) begin
                r_state <= w_next;
                if (w_next == r_origin) begin
                    r_wrap   <= 1'b1;
                    r_period <= r_cnt + WIDTH'(1);
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end

            // A load cycle inside a burst is not an advance, so rem is left alone.
            if (r_busy) begin
                if (!bus.load) begin
                    r_rem <= r_rem - 16'd1;
                    if (r_rem == 16'd1) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end else if (w_burst_req) begin
                if (bus.burst_len != 16'd0) begin
                    r_busy <= 1'b1;
                    r_rem  <= bus.burst_len;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.state_o = r_state;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.wrap    = r_wrap;
    assign bus.period  = r_period;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard bench for lfsr_gen, default 8-bit and 4-bit/taps 0x3 instances
module tb_lfsr_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];

    lfsr_gen_if #(.WIDTH(8)) bus8 ();
    lfsr_gen_if #(.WIDTH(4)) bus4 ();

    lfsr_gen u8 (.clk(clk), .rst(rst), .bus(bus8));
    lfsr_gen #(.WIDTH(4), .TAP_MASK(32'h3), .SEED(32'h1)) u4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_next8(input logic [7:0] s);
        logic [7:0] fb_bits;
        if (s == 8'h00) return 8'h01;
        fb_bits = s & 8'h1D;
        return {^fb_bits, s[7:1]};
    endfunction

    task automatic idle8();
        bus8.mode = 2'b00; bus8.step = 1'b0; bus8.start = 1'b0;
        bus8.burst_len = 16'd0; bus8.load = 1'b0; bus8.load_val = 8'h00;
    endtask

    task automatic pop_check8(input string name);
        int e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, got %h", name, bus8.state_o);
        end else begin
            e = exp_q.pop_front();
            if (bus8.state_o !== 8'(e)) begin
                errors++;
                $display("FAIL %s state got %h exp %h", name, bus8.state_o, 8'(e));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus8.state_o !== 8'h01) begin errors++; $display("FAIL reset_state got %h exp 01", bus8.state_o); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus8.done); end
        checks++; if (bus8.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", bus8.wrap); end
        checks++; if (bus8.period !== 8'h00) begin errors++; $display("FAIL reset_period got %h exp 00", bus8.period); end
        checks++; if (bus4.state_o !== 4'h1) begin errors++; $display("FAIL reset_state4 got %h exp 1", bus4.state_o); end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [7:0] seq [7];
        seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2};
        bus8.mode = 2'b01;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(int'(seq[i]));
            tick();
            pop_check8($sformatf("free_run[%0d]", i));
            checks++;
            if (bus8.wrap !== 1'b0) begin errors++; $display("FAIL free_run_wrap[%0d] got %b exp 0", i, bus8.wrap); end
        end
        idle8();
    endtask

    task automatic test_load();
        bus8.load = 1'b1; bus8.load_val = 8'h00;
        exp_q.push_back(8'h01);
        tick();
        pop_check8("load_zero");
        bus8.load_val = 8'hA5; bus8.mode = 2'b01;
        exp_q.push_back(8'hA5);
        tick();
        pop_check8("load_over_run");
        bus8.load = 1'b0; bus8.mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA5);
            tick();
            pop_check8($sformatf("hold[%0d]", i));
        end
        idle8();
    endtask

    task automatic test_burst();
        logic [7:0] s;
        int busy_cycles;
        bus8.load = 1'b1; bus8.load_val = 8'h01;
        tick();
        bus8.load = 1'b0;
        bus8.mode = 2'b11; bus8.start = 1'b1; bus8.burst_len = 16'd3;
        tick();
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL burst_start_busy got %b exp 1", bus8.busy); end
        checks++; if (bus8.state_o !== 8'h01) begin errors++; $display("FAIL burst_start_state got %h exp 01", bus8.state_o); end
        busy_cycles = 1;
        // Keep start high and flip mode to probe that both are ignored mid-burst.
        bus8.burst_len = 16'd7; bus8.mode = 2'b00;
        s = 8'h01;
        for (int i = 0; i < 3; i++) begin
            s = ref_next8(s);
            exp_q.push_back(int'(s));
            tick();
            pop_check8($sformatf("burst[%0d]", i));
            if (bus8.busy === 1'b1) busy_cycles++;
            checks++;
            if (bus8.done !== (i == 2)) begin errors++; $display("FAIL burst_done[%0d] got %b exp %b", i, bus8.done, (i == 2)); end
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL burst_busy_cycles got %0d exp 3", busy_cycles); end
        checks++; if (s !== 8'h20) begin errors++; $display("FAIL burst_model_final got %h exp 20", s); end
        bus8.start = 1'b0;
        exp_q.push_back(8'h20);
        tick();
        pop_check8("burst_after");
        checks++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin errors++; $display("FAIL burst_after_flags done %b busy %b exp 0 0", bus8.done, bus8.busy); end
        bus8.mode = 2'b11; bus8.start = 1'b1; bus8.burst_len = 16'd0;
        exp_q.push_back(8'h20);
        tick();
        pop_check8("burst_zero_state");
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL burst_zero_done got %b exp 1", bus8.done); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL burst_zero_busy got %b exp 0", bus8.busy); end
        bus8.start = 1'b0;
        tick();
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL burst_zero_done_clear got %b exp 0", bus8.done); end
        idle8();
    endtask

    task automatic test_burst_load();
        bus8.mode = 2'b11; bus8.start = 1'b1; bus8.burst_len = 16'd2;
        tick();
        bus8.start = 1'b0;
        bus8.load = 1'b1; bus8.load_val = 8'h10;
        exp_q.push_back(8'h10);
        tick();
        pop_check8("burst_load");
        bus8.load = 1'b0;
        exp_q.push_back(int'(ref_next8(8'h10)));
        tick();
        pop_check8("burst_load_adv1");
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL burst_load_busy got %b exp 1", bus8.busy); end
        exp_q.push_back(int'(ref_next8(ref_next8(8'h10))));
        tick();
        pop_check8("burst_load_adv2");
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL burst_load_done got %b exp 1", bus8.done); end
        idle8();
        tick();
    endtask

    task automatic test_step();
        logic [7:0] s;
        logic       pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus8.load = 1'b1; bus8.load_val = 8'h20;
        tick();
        bus8.load = 1'b0; bus8.mode = 2'b10;
        s = 8'h20;
        for (int i = 0; i < 4; i++) begin
            bus8.step = pat[i];
            if (pat[i]) s = ref_next8(s);
            exp_q.push_back(int'(s));
            tick();
            pop_check8($sformatf("step[%0d]", i));
        end
        checks++; if (bus8.state_o !== 8'h88) begin errors++; $display("FAIL step_final got %h exp 88", bus8.state_o); end
        idle8();
    endtask

    task automatic test_rst_mid_burst();
        bus8.mode = 2'b11; bus8.start = 1'b1; bus8.burst_len = 16'd5;
        tick();
        bus8.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_burst_busy got %b exp 0", bus8.busy); end
        checks++; if (bus8.state_o !== 8'h01) begin errors++; $display("FAIL rst_burst_state got %h exp 01", bus8.state_o); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rst_burst_done got %b exp 0", bus8.done); end
        tick();
        checks++; if (bus8.done !== 1'b0 || bus8.state_o !== 8'h01) begin errors++; $display("FAIL rst_burst_after done %b state %h exp 0 01", bus8.done, bus8.state_o); end
        idle8();
    endtask

    task automatic test_wrap4();
        logic [3:0] seq [15];
        seq = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        checks++; if (bus4.state_o !== 4'h1) begin errors++; $display("FAIL wrap4_start got %h exp 1", bus4.state_o); end
        bus4.mode = 2'b01;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (bus4.state_o !== seq[i]) begin errors++; $display("FAIL wrap4_state[%0d] got %h exp %h", i, bus4.state_o, seq[i]); end
            checks++;
            if (bus4.wrap !== (i == 14)) begin errors++; $display("FAIL wrap4_wrap[%0d] got %b exp %b", i, bus4.wrap, (i == 14)); end
        end
        checks++; if (bus4.period !== 4'd15) begin errors++; $display("FAIL wrap4_period got %0d exp 15", bus4.period); end
        bus4.mode = 2'b00;
        tick();
        checks++; if (bus4.wrap !== 1'b0) begin errors++; $display("FAIL wrap4_wrap_clear got %b exp 0", bus4.wrap); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle8();
        bus4.mode = 2'b00; bus4.step = 1'b0; bus4.start = 1'b0;
        bus4.burst_len = 16'd0; bus4.load = 1'b0; bus4.load_val = 4'h0;
        test_reset();
        test_free_run();
        test_load();
        test_burst();
        test_burst_load();
        test_step();
        test_wrap4();
        test_rst_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
